// File: rtl/layer_serializer_if.sv
// Bus between a fully connected layer's parallel outputs and the next
// layer's serial input port, plus the serializer's status flags.
interface layer_serializer_if #(
  parameter int NN        = 30,
  parameter int dataWidth = 16
);
  logic [NN-1:0]           o_valid;
  logic [NN*dataWidth-1:0] x_out;
  logic                    x_valid;
  logic [dataWidth-1:0]    x_in;
  logic                    busy;
  logic                    frame_done;
  logic                    overrun;
  logic                    misalign;

  // Producing layer side: drives the parallel frame, observes the stream.
  modport master (
    output o_valid, x_out,
    input  x_valid, x_in, busy, frame_done, overrun, misalign
  );

  // Serializer side: consumes the parallel frame, drives the stream.
  modport slave (
    input  o_valid, x_out,
    output x_valid, x_in, busy, frame_done, overrun, misalign
  );
endinterface

// File: rtl/layer_serializer.sv
// Captures a parallel NN-neuron result vector and replays it as a serial
// one-sample-per-cycle stream, neuron 0 first. Flags dropped frames
// (overrun) and partial valid vectors (misalign); both are sticky.
module layer_serializer #(
  parameter int NN        = 30,
  parameter int dataWidth = 16
) (
  input  logic              clk,
  input  logic              rst,
  layer_serializer_if.slave bus
);
  localparam int CW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NN - 1);
  localparam logic [CW-1:0] CNT_PEN  = CW'(NN - 2);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [dataWidth-1:0] hold_q [NN];
  logic [dataWidth-1:0] hold_d [NN];
  logic                 x_valid_q, x_valid_d;
  logic [dataWidth-1:0] x_in_q, x_in_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic                 overrun_q, overrun_d;
  logic                 misalign_q, misalign_d;

  logic                 trigger_s;
  logic                 aligned_s;
  logic                 last_s;
  logic                 sending_s;
  logic                 capture_s;
  logic [CW-1:0]        cnt_inc_s;

  // Next-state logic: cnt_q indexes the sample currently on x_in, so the
  // output registers are loaded with the sample for the following cycle.
  always_comb begin
    trigger_s = bus.o_valid[0];
    aligned_s = (bus.o_valid == {NN{1'b1}});
    sending_s = (state_q == SEND);
    last_s    = sending_s && (cnt_q == CNT_LAST);
    // A new frame is taken when idle or exactly on the last sample.
    capture_s = trigger_s && ((state_q == IDLE) || last_s);
    cnt_inc_s = cnt_q + CNT_ONE;

    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    x_valid_d    = 1'b0;
    x_in_d       = x_in_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q | (trigger_s && sending_s && !last_s);
    misalign_d   = misalign_q | (trigger_s && !aligned_s);

    if (capture_s) begin
      for (int i = 0; i < NN; i++) begin
        hold_d[i] = bus.x_out[i*dataWidth +: dataWidth];
      end
      state_d   = SEND;
      cnt_d     = CNT_ZERO;
      x_valid_d = 1'b1;
      // Sample 0 goes out straight from the bus since hold is loading now.
      x_in_d    = bus.x_out[dataWidth-1:0];
    end else if (sending_s && !last_s) begin
      state_d      = SEND;
      cnt_d        = cnt_inc_s;
      x_valid_d    = 1'b1;
      x_in_d       = hold_q[cnt_inc_s];
      frame_done_d = (cnt_q == CNT_PEN);
    end else begin
      state_d = IDLE;
      cnt_d   = CNT_ZERO;
    end

    busy_d = x_valid_d;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= CNT_ZERO;
      for (int i = 0; i < NN; i++) begin
        hold_q[i] <= {dataWidth{1'b0}};
      end
      x_valid_q    <= 1'b0;
      x_in_q       <= {dataWidth{1'b0}};
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      for (int i = 0; i < NN; i++) begin
        hold_q[i] <= hold_d[i];
      end
      x_valid_q    <= x_valid_d;
      x_in_q       <= x_in_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      misalign_q   <= misalign_d;
    end
  end

  assign bus.x_valid    = x_valid_q;
  assign bus.x_in       = x_in_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overrun    = overrun_q;
  assign bus.misalign   = misalign_q;
endmodule

// File: tb/tb_layer_serializer.sv
// Bench for layer_serializer: an NN=4 and an NN=30 instance share clock and
// reset. A queue model predicts every output each cycle; directed scenarios
// also check the collected stream against literal payloads.
module tb_layer_serializer;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  layer_serializer_if #(.NN(4),  .dataWidth(16)) i4 ();
  layer_serializer_if #(.NN(30), .dataWidth(16)) i30 ();

  layer_serializer #(.NN(4), .dataWidth(16)) u4 (.clk(clk), .rst(rst), .bus(i4));
  layer_serializer #(.NN(30), .dataWidth(16)) u30 (.clk(clk), .rst(rst), .bus(i30));

  always #5 clk = ~clk;

  // Reference model: samples still to be emitted, plus the visible outputs.
  logic [15:0] mq [2][64];
  int          mhead [2];
  int          mcnt [2];
  logic        mv [2];
  logic        mfd [2];
  logic        mov [2];
  logic        mmis [2];
  logic [15:0] mx [2];

  task automatic model_edge(input int id, input int n, input logic rv,
                            input logic [29:0] ov, input logic [479:0] xo);
    logic allone;
    if (!rv) begin
      mhead[id] = 0; mcnt[id] = 0; mv[id] = 1'b0; mfd[id] = 1'b0;
      mov[id] = 1'b0; mmis[id] = 1'b0; mx[id] = 16'h0000;
    end else begin
      if (ov[0]) begin
        allone = 1'b1;
        for (int i = 0; i < n; i++) if (!ov[i]) allone = 1'b0;
        if (!allone) mmis[id] = 1'b1;
        if (mcnt[id] == 0) begin
          for (int k = 0; k < n; k++) begin
            mq[id][(mhead[id] + mcnt[id]) % 64] = xo[k*16 +: 16];
            mcnt[id]++;
          end
        end else begin
          mov[id] = 1'b1;
        end
      end
      if (mcnt[id] > 0) begin
        mx[id] = mq[id][mhead[id]];
        mhead[id] = (mhead[id] + 1) % 64;
        mcnt[id]--;
        mv[id] = 1'b1;
        mfd[id] = (mcnt[id] == 0);
      end else begin
        mv[id] = 1'b0;
        mfd[id] = 1'b0;
      end
    end
  endtask

  function automatic logic [20:0] expv(input int id);
    return {mv[id], mv[id], mfd[id], mov[id], mmis[id], mx[id]};
  endfunction

  function automatic logic [20:0] act(input int id);
    if (id == 0) return {i4.x_valid, i4.busy, i4.frame_done, i4.overrun, i4.misalign, i4.x_in};
    else         return {i30.x_valid, i30.busy, i30.frame_done, i30.overrun, i30.misalign, i30.x_in};
  endfunction

  task automatic drive4(input logic [3:0] ov, input logic [63:0] xo);
    i4.o_valid = ov;
    i4.x_out   = xo;
  endtask

  task automatic drive30(input logic [29:0] ov, input logic [479:0] xo);
    i30.o_valid = ov;
    i30.x_out   = xo;
  endtask

  // One clock: model consumes the inputs seen at the edge; returns mid-cycle.
  task automatic step();
    @(posedge clk);
    model_edge(0, 4, rst, {26'b0, i4.o_valid}, {416'b0, i4.x_out});
    model_edge(1, 30, rst, i30.o_valid, i30.x_out);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive4(4'b0000, 64'h0);
    drive30(30'd0, 480'h0);
    step();
    step();
    total++;
    if (act(0) !== 21'h0) begin bad++; $display("FAIL reset_nn4: got %h want %h", act(0), 21'h0); end
    total++;
    if (act(1) !== 21'h0) begin bad++; $display("FAIL reset_nn30: got %h want %h", act(1), 21'h0); end
    rst = 1'b1;
  endtask

  task automatic test_single();
    logic [15:0] seen [$];
    int fds = 0;
    int fd_at = -1;
    for (int c = 0; c < 7; c++) begin
      if (c == 0) drive4(4'b1111, 64'h0004_0003_0002_0001);
      else        drive4(4'b0000, 64'h0);
      step();
      total++;
      if (act(0) !== expv(0)) begin bad++; $display("FAIL single_c%0d: got %h want %h", c, act(0), expv(0)); end
      if (i4.x_valid === 1'b1) seen.push_back(i4.x_in);
      if (i4.frame_done === 1'b1) begin fds++; fd_at = c; end
    end
    total++;
    if (seen.size() != 4 || fds != 1 || fd_at != 3) begin
      bad++; $display("FAIL single_shape: got n=%0d fd=%0d at %0d want n=4 fd=1 at 3", seen.size(), fds, fd_at);
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (seen[k] !== 16'(k + 1)) begin bad++; $display("FAIL single_s%0d: got %h want %h", k, seen[k], 16'(k + 1)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seen [$];
    int fds = 0;
    int runlen = 0;
    int maxrun = 0;
    for (int c = 0; c < 11; c++) begin
      if (c == 0)      drive4(4'b1111, 64'h0004_0003_0002_0001);
      else if (c == 4) drive4(4'b1111, 64'h0014_0013_0012_0011);
      else             drive4(4'b0000, 64'h0);
      step();
      total++;
      if (act(0) !== expv(0)) begin bad++; $display("FAIL b2b_c%0d: got %h want %h", c, act(0), expv(0)); end
      if (i4.x_valid === 1'b1) begin seen.push_back(i4.x_in); runlen++; end
      else runlen = 0;
      if (runlen > maxrun) maxrun = runlen;
      if (i4.frame_done === 1'b1) fds++;
    end
    total++;
    if (seen.size() != 8 || maxrun != 8 || fds != 2 || i4.overrun !== 1'b0) begin
      bad++; $display("FAIL b2b_shape: got n=%0d run=%0d fd=%0d ovr=%b want 8 8 2 0", seen.size(), maxrun, fds, i4.overrun);
    end else begin
      for (int k = 0; k < 8; k++) begin
        logic [15:0] w;
        w = (k < 4) ? 16'(k + 1) : 16'(k - 4 + 16'h11);
        total++;
        if (seen[k] !== w) begin bad++; $display("FAIL b2b_s%0d: got %h want %h", k, seen[k], w); end
      end
    end
  endtask

  task automatic test_overrun();
    logic [15:0] seen [$];
    for (int c = 0; c < 10; c++) begin
      if (c == 0)      drive4(4'b1111, 64'h0004_0003_0002_0001);
      else if (c == 2) drive4(4'b1111, 64'h00AD_00AC_00AB_00AA);
      else             drive4(4'b0000, 64'h0);
      step();
      total++;
      if (act(0) !== expv(0)) begin bad++; $display("FAIL ovr_c%0d: got %h want %h", c, act(0), expv(0)); end
      if (i4.x_valid === 1'b1) seen.push_back(i4.x_in);
    end
    total++;
    if (seen.size() != 4 || seen[0] !== 16'h1 || seen[1] !== 16'h2 || seen[2] !== 16'h3 || seen[3] !== 16'h4 || i4.overrun !== 1'b1) begin
      bad++; $display("FAIL ovr_stream: got n=%0d ovr=%b want n=4 values 1..4 ovr=1", seen.size(), i4.overrun);
    end
  endtask

  task automatic test_misalign();
    logic [15:0] seen [$];
    int nv = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 0) drive4(4'b0111, 64'h0004_0003_0002_0001);
      else        drive4(4'b0000, 64'h0);
      step();
      total++;
      if (act(0) !== expv(0)) begin bad++; $display("FAIL mis_c%0d: got %h want %h", c, act(0), expv(0)); end
      if (i4.x_valid === 1'b1) seen.push_back(i4.x_in);
    end
    total++;
    if (seen.size() != 4 || seen[0] !== 16'h1 || seen[3] !== 16'h4 || i4.misalign !== 1'b1) begin
      bad++; $display("FAIL mis_frame: got n=%0d mis=%b want n=4 mis=1", seen.size(), i4.misalign);
    end
    for (int c = 0; c < 5; c++) begin
      if (c == 0) drive4(4'b1110, 64'h00AD_00AC_00AB_00AA);
      else        drive4(4'b0000, 64'h0);
      step();
      total++;
      if (act(0) !== expv(0)) begin bad++; $display("FAIL nocap_c%0d: got %h want %h", c, act(0), expv(0)); end
      if (i4.x_valid === 1'b1) nv++;
    end
    total++;
    if (nv != 0) begin bad++; $display("FAIL nocap_valid: got %0d samples want 0", nv); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] seen [$];
    int nv = 0;
    for (int c = 0; c < 7; c++) begin
      drive4(c == 0 ? 4'b1111 : 4'b0000, c == 0 ? 64'h0004_0003_0002_0001 : 64'h0);
      rst = (c == 2) ? 1'b0 : 1'b1;
      step();
      total++;
      if (act(0) !== expv(0)) begin bad++; $display("FAIL rmid_c%0d: got %h want %h", c, act(0), expv(0)); end
      if (c == 2) begin
        total++;
        if (act(0) !== 21'h0) begin bad++; $display("FAIL rmid_clear: got %h want %h", act(0), 21'h0); end
      end
      if (c >= 2 && i4.x_valid === 1'b1) nv++;
    end
    total++;
    if (nv != 0) begin bad++; $display("FAIL rmid_tail: got %0d samples want 0", nv); end
    for (int c = 0; c < 6; c++) begin
      drive4(c == 0 ? 4'b1111 : 4'b0000, c == 0 ? 64'h0004_0003_0002_0001 : 64'h0);
      step();
      total++;
      if (act(0) !== expv(0)) begin bad++; $display("FAIL rfresh_c%0d: got %h want %h", c, act(0), expv(0)); end
      if (i4.x_valid === 1'b1) seen.push_back(i4.x_in);
    end
    total++;
    if (seen.size() != 4 || seen[0] !== 16'h1 || seen[1] !== 16'h2 || seen[2] !== 16'h3 || seen[3] !== 16'h4) begin
      bad++; $display("FAIL rfresh_stream: got n=%0d want 4 samples 1..4", seen.size());
    end
  endtask

  task automatic test_nn30();
    logic [479:0] pay;
    logic [15:0] seen [$];
    int fds = 0;
    int fd_idx = -1;
    for (int k = 0; k < 15; k++) pay[k*32 +: 32] = $urandom();
    for (int c = 0; c < 34; c++) begin
      drive30(c == 0 ? {30{1'b1}} : 30'd0, c == 0 ? pay : 480'h0);
      step();
      total++;
      if (act(1) !== expv(1)) begin bad++; $display("FAIL nn30_c%0d: got %h want %h", c, act(1), expv(1)); end
      if (i30.x_valid === 1'b1) seen.push_back(i30.x_in);
      if (i30.frame_done === 1'b1) begin fds++; fd_idx = seen.size(); end
    end
    total++;
    if (seen.size() != 30 || fds != 1 || fd_idx != 30) begin
      bad++; $display("FAIL nn30_shape: got n=%0d fd=%0d at %0d want 30 1 30", seen.size(), fds, fd_idx);
    end else begin
      for (int k = 0; k < 30; k++) begin
        total++;
        if (seen[k] !== pay[k*16 +: 16]) begin bad++; $display("FAIL nn30_s%0d: got %h want %h", k, seen[k], pay[k*16 +: 16]); end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      logic [3:0]   ov;
      logic [29:0]  ov30;
      logic [479:0] xo30;
      ov = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) ov[0] = 1'b0;
      else if ($urandom_range(0, 2) != 0) ov = 4'b1111;
      if ($urandom_range(0, 11) == 0)
        ov30 = ($urandom_range(0, 3) == 0) ? (30'($urandom()) | 30'd1) : {30{1'b1}};
      else
        ov30 = 30'd0;
      for (int k = 0; k < 15; k++) xo30[k*32 +: 32] = $urandom();
      drive4(ov, {$urandom(), $urandom()});
      drive30(ov30, xo30);
      rst = ($urandom_range(0, 80) == 0) ? 1'b0 : 1'b1;
      step();
      total++;
      if (act(0) !== expv(0)) begin bad++; $display("FAIL rnd4_c%0d: got %h want %h", c, act(0), expv(0)); end
      total++;
      if (act(1) !== expv(1)) begin bad++; $display("FAIL rnd30_c%0d: got %h want %h", c, act(1), expv(1)); end
    end
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    drive4(4'b0000, 64'h0);
    drive30(30'd0, 480'h0);
    for (int id = 0; id < 2; id++) begin
      mhead[id] = 0; mcnt[id] = 0; mv[id] = 1'b0; mfd[id] = 1'b0;
      mov[id] = 1'b0; mmis[id] = 1'b0; mx[id] = 16'h0000;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_misalign();
    test_reset_mid();
    test_nn30();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
